// File: rtl/rx_channel_decimator.sv
// rtl/rx_channel_decimator.sv - per-lane boxcar average and decimate-by-2^k for lock-stepped ADC channels
// Optional RX_DECIM_ROUND_EN: round half up before the shift instead of truncating toward -inf.
module rx_channel_decimator #(
   parameter int CHANNELS         = 8,
   parameter int PARALLEL_SAMPLES = 8,
   parameter int SAMPLE_WIDTH     = 16,
   parameter int MAX_DECIM_LOG2   = 4
) (
   input  logic                                                clk,
   input  logic                                                reset_n,
   input  logic [CHANNELS*PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0]   s_data,
   input  logic                                                s_valid,
   output logic                                                s_ready,
   output logic [CHANNELS*PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0]   m_data,
   output logic                                                m_valid,
   input  logic                                                m_ready,
   input  logic [$clog2(MAX_DECIM_LOG2+1)-1:0]                 cfg_decim_log2,
   input  logic                                                cfg_valid
);
   localparam int LANES = CHANNELS * PARALLEL_SAMPLES;
   localparam int AW    = SAMPLE_WIDTH + MAX_DECIM_LOG2;
   localparam int KW    = $clog2(MAX_DECIM_LOG2 + 1);
   localparam int CW    = (MAX_DECIM_LOG2 > 0) ? MAX_DECIM_LOG2 : 1;

   logic [KW-1:0]        k_active, k_pending, k_cfg, k_sel, k_cur;
   logic [CW-1:0]        count, last_cnt;
   logic                 accept, frame_done;
   logic signed [AW-1:0] acc [LANES];
   logic signed [AW-1:0] sum [LANES];
   logic signed [AW-1:0] rnd;

   assign s_ready = !(m_valid && !m_ready);
   assign accept  = s_valid && s_ready;

   assign k_cfg = (cfg_decim_log2 > KW'(MAX_DECIM_LOG2)) ? KW'(MAX_DECIM_LOG2) : cfg_decim_log2;
   assign k_sel = cfg_valid ? k_cfg : k_pending;
   // At counter 0 the frame has not started, so a fresh setting (even one arriving this cycle) governs it.
   assign k_cur = (count == '0) ? k_sel : k_active;

   always_comb begin
      last_cnt = '0;
      for (int i = 0; i < CW; i++) begin
         last_cnt[i] = (KW'(i) < k_cur);
      end
   end

   assign frame_done = accept && (count == last_cnt);

`ifdef RX_DECIM_ROUND_EN
   assign rnd = (k_cur == '0) ? '0 : (AW'(1) <<< (k_cur - KW'(1)));
`else
   assign rnd = '0;
`endif

   // First word of a frame loads the accumulator instead of adding to the stale sum.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         sum[l] = ((count == '0) ? '0 : acc[l])
                + AW'($signed(s_data[l*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count     <= '0;
         k_active  <= '0;
         k_pending <= '0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         for (int l = 0; l < LANES; l++) begin
            acc[l] <= '0;
         end
      end else begin
         if (cfg_valid) begin
            k_pending <= k_cfg;
         end
         if (count == '0) begin
            k_active <= k_sel;
         end
         if (accept) begin
            count <= frame_done ? '0 : count + 1'b1;
            for (int l = 0; l < LANES; l++) begin
               acc[l] <= sum[l];
            end
         end
         if (frame_done) begin
            m_valid <= 1'b1;
            for (int l = 0; l < LANES; l++) begin
               m_data[l*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= SAMPLE_WIDTH'((sum[l] + rnd) >>> k_cur);
            end
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end
endmodule
